// File: rtl/ddr3_wr_packer.sv
// rtl/ddr3_wr_packer.sv - packs narrow framed beats into full-width DDR3 FIFO words
module ddr3_wr_packer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_vld,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_sof,
    input  logic                 din_eof,
    output logic                 fifo_wren,
    output logic [OUT_WIDTH-1:0] fifo_wrdata,
    input  logic                 fifo_full,
    input  logic                 fifo_rst_busy,
    output logic                 wr_addr_clr,
    output logic                 frame_done,
    output logic [15:0]          frm_word_cnt,
    output logic [15:0]          ovf_cnt
);

    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int LW    = $clog2(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PACK = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [OUT_WIDTH-1:0]  word_q, word_d;
    logic                  wren_q, wren_d;
    logic [OUT_WIDTH-1:0]  wrdata_q, wrdata_d;
    logic                  clr_q, clr_d;
    logic                  done_q, done_d;
    logic [15:0]           frm_q, frm_d;
    logic [15:0]           ovf_q, ovf_d;

    // Combinational working values for the current beat
    logic                  is_sof;
    logic                  accept;
    logic                  complete;
    logic                  blocked;
    logic [LW-1:0]         lane_idx;
    logic [OUT_WIDTH-1:0]  base;
    logic [OUT_WIDTH-1:0]  merged;

    // Next-state: FSM transitions, lane packing, write/drop decision and counters
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        word_d   = word_q;
        wren_d   = 1'b0;
        wrdata_d = wrdata_q;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        frm_d    = frm_q;
        ovf_d    = ovf_q;
        is_sof   = din_vld && din_sof;
        accept   = din_vld && (din_sof || (state_q == S_PACK));
        blocked  = fifo_full || fifo_rst_busy;
        complete = 1'b0;

        // A sof beat discards any partial word and restarts packing at lane 0
        if (is_sof) begin
            clr_d    = 1'b1;
            frm_d    = 16'd0;
            base     = '0;
            lane_idx = '0;
        end else begin
            base     = word_q;
            lane_idx = lane_q;
        end

        merged = base;
        for (int k = 0; k < RATIO; k++) begin
            if (k == int'(lane_idx)) begin
                merged[k*IN_WIDTH +: IN_WIDTH] = din;
            end
        end

        if (accept) begin
            complete = (lane_idx == LAST_LANE) || din_eof;
            if (complete) begin
                // Clearing the accumulator is what zero-pads a short final word
                word_d = '0;
                lane_d = '0;
                done_d = din_eof;
                if (!blocked) begin
                    wren_d   = 1'b1;
                    wrdata_d = merged;
                    if (frm_d != 16'hFFFF) begin
                        frm_d = frm_d + 16'd1;
                    end
                end else if (ovf_q != 16'hFFFF) begin
                    ovf_d = ovf_q + 16'd1;
                end
                state_d = din_eof ? S_IDLE : S_PACK;
            end else begin
                word_d  = merged;
                lane_d  = lane_idx + LW'(1);
                state_d = S_PACK;
            end
        end
    end

    // State and output registers; asynchronous reset drops any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            word_q   <= '0;
            wren_q   <= 1'b0;
            wrdata_q <= '0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            frm_q    <= 16'd0;
            ovf_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            word_q   <= word_d;
            wren_q   <= wren_d;
            wrdata_q <= wrdata_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
            frm_q    <= frm_d;
            ovf_q    <= ovf_d;
        end
    end

    assign fifo_wren    = wren_q;
    assign fifo_wrdata  = wrdata_q;
    assign wr_addr_clr  = clr_q;
    assign frame_done   = done_q;
    assign frm_word_cnt = frm_q;
    assign ovf_cnt      = ovf_q;

endmodule
